// File: rtl/caesar_cipher_engine.sv
// Caesar-shift cipher engine: encrypts or decrypts a MSG_LEN-character ASCII
// message one character per clock, using the fixed shift key SEC_LEN.
module caesar_cipher_engine #(
  parameter int MSG_LEN = 6,
  parameter int SEC_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [8*MSG_LEN-1:0] text_in,
  output logic [8*MSG_LEN-1:0] text_out,
  output logic                 busy,
  output logic                 done
);

  localparam int               IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
  localparam logic [5:0]       KEY_ENC  = 6'(SEC_LEN);
  localparam logic [5:0]       KEY_DEC  = 6'(26 - SEC_LEN);

  generate
    if (SEC_LEN < 0 || SEC_LEN > 25) begin : g_bad_key
      $error("caesar_cipher_engine: SEC_LEN must be in 0..25");
    end
    if (MSG_LEN < 1) begin : g_bad_len
      $error("caesar_cipher_engine: MSG_LEN must be at least 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_r;
  logic [IDX_W-1:0]       idx_r;
  logic                   mode_r;
  logic [8*MSG_LEN-1:0]   work_r;
  logic [8*MSG_LEN-1:0]   res_r;
  logic [8*MSG_LEN-1:0]   next_res_s;

  // Letters rotate within their own case; the offset sum never exceeds 51,
  // so one conditional subtract of 26 is a complete modulo.
  function automatic logic [7:0] shift_char(input logic [7:0] c, input logic dec);
    logic [7:0] base;
    logic [5:0] sum;
    logic       is_letter;
    if (c >= 8'd65 && c <= 8'd90) begin
      base      = 8'd65;
      is_letter = 1'b1;
    end else if (c >= 8'd97 && c <= 8'd122) begin
      base      = 8'd97;
      is_letter = 1'b1;
    end else begin
      base      = 8'd0;
      is_letter = 1'b0;
    end
    sum = 6'(c - base) + (dec ? KEY_DEC : KEY_ENC);
    if (sum >= 6'd26) begin
      sum = sum - 6'd26;
    end else begin
      sum = sum;
    end
    return is_letter ? (base + {2'b00, sum}) : c;
  endfunction

  // Result buffer with the current character replaced by its transformed value.
  always_comb begin
    next_res_s = res_r;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx_r == IDX_W'(i)) begin
        next_res_s[8*i +: 8] = shift_char(work_r[8*i +: 8], mode_r);
      end else begin
        next_res_s[8*i +: 8] = res_r[8*i +: 8];
      end
    end
  end

  // Control FSM, working/result buffers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= {IDX_W{1'b0}};
      mode_r   <= 1'b0;
      work_r   <= {(8*MSG_LEN){1'b0}};
      res_r    <= {(8*MSG_LEN){1'b0}};
      text_out <= {(8*MSG_LEN){1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            work_r  <= text_in;
            mode_r  <= mode;
            idx_r   <= {IDX_W{1'b0}};
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_r <= next_res_s;
          if (idx_r == LAST_IDX) begin
            text_out <= next_res_s;
            done     <= 1'b1;
            busy     <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
            state_r  <= ST_IDLE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= {IDX_W{1'b0}};
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_caesar_cipher_engine.sv
// Self-checking bench for caesar_cipher_engine: directed vectors, protocol
// corner cases and randomized messages against an arithmetic reference model.
module tb_caesar_cipher_engine;

  localparam int MSG_LEN = 6;
  localparam int SEC_LEN = 3;
  localparam int W       = 8 * MSG_LEN;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] text_in = '0;
  logic [W-1:0] text_out;
  logic         busy;
  logic         done;

  int tests_run    = 0;
  int tests_failed = 0;

  caesar_cipher_engine #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .text_in (text_in),
    .text_out(text_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input string s);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < MSG_LEN && i < s.len(); i++) v[8*i +: 8] = s[i];
    return v;
  endfunction

  // Reference: plain integer modular arithmetic on each character.
  function automatic logic [W-1:0] model(input logic [W-1:0] t, input logic dec);
    logic [W-1:0] r;
    int c, k;
    k = dec ? (26 - SEC_LEN) : SEC_LEN;
    for (int i = 0; i < MSG_LEN; i++) begin
      c = int'(t[8*i +: 8]);
      if (c >= 65 && c <= 90)       c = 65 + (c - 65 + k) % 26;
      else if (c >= 97 && c <= 122) c = 97 + (c - 97 + k) % 26;
      r[8*i +: 8] = 8'(c);
    end
    return r;
  endfunction

  // Runs one operation; disturb re-pulses start mid-run and scrambles inputs.
  task automatic do_op(input string tag, input logic [W-1:0] txt, input logic m,
                       input logic disturb, output logic [W-1:0] res);
    int lat;
    @(negedge clk);
    text_in = txt;
    mode    = m;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (disturb) begin
      text_in = ~txt;
      mode    = ~m;
    end
    check({tag, "_busy_hi"}, 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 20) begin
      if (disturb && lat == 2) start = 1'b1;
      else start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(MSG_LEN));
    check({tag, "_busy_lo"}, 64'(busy), 64'd0);
    res = text_out;
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] r, r2, t, v;
    logic         m;
    int           n, seen;

    #12;
    check("rst_text_out", 64'(text_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("enc_hellow", pack("HELLOW"), 1'b0, 1'b0, r);
    check("enc_hellow_val", 64'(r), 64'(pack("KHOORZ")));
    do_op("dec_khoorz", pack("KHOORZ"), 1'b1, 1'b0, r);
    check("dec_khoorz_val", 64'(r), 64'(pack("HELLOW")));
    do_op("enc_mixed", pack("HeLloW"), 1'b0, 1'b0, r);
    check("enc_mixed_val", 64'(r), 64'(pack("KhOorZ")));
    do_op("dec_mixed", r, 1'b1, 1'b0, r2);
    check("dec_mixed_val", 64'(r2), 64'(pack("HeLloW")));
    do_op("enc_wrap", pack("XYZxyz"), 1'b0, 1'b0, r);
    check("enc_wrap_val", 64'(r), 64'(pack("ABCabc")));
    do_op("dec_wrap", pack("ABCabc"), 1'b1, 1'b0, r);
    check("dec_wrap_val", 64'(r), 64'(pack("XYZxyz")));
    t = pack("A1 !~");
    t[47:40] = 8'hFF;
    v = pack("D1 !~");
    v[47:40] = 8'hFF;
    do_op("enc_pass", t, 1'b0, 1'b0, r);
    check("enc_pass_val", 64'(r), 64'(v));

    do_op("disturb", pack("HELLOW"), 1'b0, 1'b1, r);
    check("disturb_val", 64'(r), 64'(pack("KHOORZ")));
    // idle on the disturbed start: must not have launched a second run
    check("disturb_idle", 64'(busy), 64'd0);

    // Held start: consecutive done pulses MSG_LEN+1 cycles apart
    @(negedge clk);
    text_in = pack("abcxyz");
    mode    = 1'b0;
    start   = 1'b1;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    check("b2b_first", 64'(text_out), 64'(pack("defabc")));
    n = 0;
    seen = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 && done) seen = 1;
    end while (!done && n < 20);
    check("b2b_spacing", 64'(n), 64'(MSG_LEN + 1));
    check("b2b_single_pulse", 64'(seen), 64'd0);
    start = 1'b0;
    n = 0;
    while ((busy || done) && n < 20) begin @(posedge clk); #1; n++; end

    // Reset at cycle 3 of RUN
    @(negedge clk);
    text_in = pack("Zebras");
    mode    = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_run_busy", 64'(busy), 64'd0);
    check("rst_run_done", 64'(done), 64'd0);
    check("rst_run_text", 64'(text_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (done) seen = 1; end
    check("rst_no_done", 64'(seen), 64'd0);
    do_op("post_rst", pack("Zebras"), 1'b0, 1'b0, r);
    check("post_rst_val", 64'(r), 64'(model(pack("Zebras"), 1'b0)));

    // Randomized messages and round trips
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < MSG_LEN; j++) begin
        case ($urandom_range(0, 3))
          0:       t[8*j +: 8] = 8'($urandom_range(65, 90));
          1:       t[8*j +: 8] = 8'($urandom_range(97, 122));
          default: t[8*j +: 8] = 8'($urandom_range(0, 255));
        endcase
      end
      m = 1'($urandom_range(0, 1));
      do_op("rand", t, m, 1'($urandom_range(0, 1)), r);
      check("rand_val", 64'(r), 64'(model(t, m)));
      do_op("rand_rt", r, ~m, 1'b0, r2);
      check("rand_roundtrip", 64'(r2), 64'(t));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/caesar_cipher_engine.md
# caesar_cipher_engine

Sequential Caesar-shift cipher engine that encrypts or decrypts a fixed-length ASCII message, one character per clock. It sits between the message buffer and the transport path, and provides both the encryptor and decryptor functions selected per operation. A round trip (encrypt, then decrypt with the same key) must return the original text byte-for-byte, including letter case.

## Interface
Clocking: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).

Parameters:
- `MSG_LEN`, default 6: message length in characters; legal range ≥ 1.
- `SEC_LEN`, default 3: shift key; legal range 0–25 (elaboration error otherwise).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a new operation; sampled only while idle.
- `mode`  in  1  0 = encrypt, 1 = decrypt; sampled together with `start`.
- `text_in`  in  8*MSG_LEN  input message; char i occupies bits [8i+7:8i]; char 0 is the first character.
- `text_out`  out  8*MSG_LEN  result message, same packing as `text_in`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when `text_out` has been updated.

## Operation
- Per-character transform, with `k` = SEC_LEN:
  - Encrypt, 'A'–'Z' (65–90): `out = 'A' + ((c - 'A' + k) mod 26)`.
  - Encrypt, 'a'–'z' (97–122): `out = 'a' + ((c - 'a' + k) mod 26)`.
  - Decrypt: same, using `(c - base + 26 - k) mod 26`.
  - All other byte values (digits, space, punctuation, ≥128) pass through unchanged.
- Case is always preserved: uppercase maps to uppercase and lowercase to lowercase. No case conversion is performed.
- Arithmetic: do it in 6-bit unsigned on the 0–25 offset, then a single conditional subtract of 26. No 8-bit overflow is possible.
- FSM states:
  - IDLE → RUN on `start`=1: latch `text_in` into a working buffer, latch `mode`, set char index = 0.
  - RUN: each cycle, transform char[index] and write it to the result buffer; index++.
  - After index MSG_LEN-1 is written: copy the result buffer to `text_out`, pulse `done`, return to IDLE.
- `start` during RUN is ignored. Changes to `text_in` or `mode` after the start cycle do not affect the operation in flight.
- `text_out` changes only at completion or reset. It holds its value until the next completion.
- SEC_LEN = 0 is identity in both modes.

## Timing
- Reset (async assert, sync release): `text_out` = 0, `busy` = 0, `done` = 0, FSM = IDLE, index = 0.
- Reset mid-RUN aborts the operation. No `done` is produced and `text_out` is cleared.
- Let edge E0 be the rising edge that samples `start`=1 in IDLE:
  - `busy` goes high after E0.
  - Characters are processed on edges E1..E_MSG_LEN.
  - At E_MSG_LEN: `text_out` updates, `busy` falls, `done` rises.
  - `done` falls at E_MSG_LEN+1.
- Latency from start edge to valid result: MSG_LEN cycles.
- Back-to-back: `start` held high in the `done` cycle is accepted at E_MSG_LEN+1. Throughput is one message per MSG_LEN+1 cycles.

## Test plan
- Encrypt "HELLOW" (72,69,76,76,79,87), k=3 → `text_out` = 75,72,79,79,82,90 ("KHOORZ"); `done` pulses exactly 6 cycles after the start edge.
- Decrypt 75,72,79,79,82,90, k=3 → "HELLOW". Also decrypt an encrypted "HeLloW" → "HeLloW", confirming lowercase is preserved.
- Wrap-around, k=3: encrypt "XYZxyz" → "ABCabc"; decrypt "ABCabc" → "XYZxyz".
- Pass-through: encrypt "A1 !~" plus byte 0xFF → "D1 !~" plus 0xFF; non-letters are unchanged.
- Protocol:
  - Pulse `start` again at mid-RUN → ignored; result and timing unchanged.
  - Change `text_in` after the start edge → no effect on the result.
  - Hold `start` high continuously → consecutive `done` pulses 7 cycles apart.
- Reset: assert `rst_n`=0 at cycle 3 of RUN → `busy`, `done`, `text_out` all 0 immediately; no `done` pulse after release; the next operation completes normally.
